ula_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 8-bit ALU (ula_8_bits, 74181 cascade) between NREQ requesters.
- Each requester presents a complete ALU operation (a, b, s, m, c_in) under a valid/ready handshake.
- The block grants one requester, drives the ALU from a registered operand stage, and captures f/a_eq_b/c_out.
- It returns the result tagged with the requester id under a valid/ready response handshake.
- The ALU instance sits outside this block, on the alu_* ports.

---
 rtl/ula_arb_pkg.sv | 31 +++
 rtl/ula_rr_grant.sv | 53 +++++
 rtl/ula_arbiter.sv | 169 ++++++++++++++++
 tb/tb_ula_arbiter.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ula_arb_pkg
//  Description : Shared types and constants for the ula_arbiter slice.
//                Holds the FSM state enum, ALU field widths and the packed
//                operand record latched for the granted requester.
//  Revision    : 1.0 - initial release
// ============================================================================
package ula_arb_pkg;

    localparam int ULA_W    = 8;    // ALU data width
    localparam int ULA_SW   = 4;    // ALU function-select width
    localparam int MAX_NREQ = 4;    // largest supported requester count
    localparam int STAT_W   = 16;   // per-requester grant counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [ULA_W-1:0]  a;
        logic [ULA_W-1:0]  b;
        logic [ULA_SW-1:0] s;
        logic              m;
        logic              cin;
    } ula_op_t;

endpackage : ula_arb_pkg
`default_nettype wire

// File: rtl/ula_rr_grant.sv
`default_nettype none
// ============================================================================
//  Module      : ula_rr_grant
//  Description : Combinational round-robin grant. Searches req_i starting at
//                ptr_i+1 (mod NREQ), wrapping, and returns a one-hot grant,
//                its binary index and an "any request" flag. No state.
//  Ports       : req_i    - per-requester valid
//                ptr_i    - index of the last accepted grant
//                gnt_o    - one-hot grant (all zero when no request)
//                gnt_id_o - binary index of the granted requester
//                any_o    - at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module ula_rr_grant #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_id_o,
    output logic            any_o
);

    int w_best;
    int w_sel;
    int w_dist;

    // Each requester's distance from the slot just after the pointer; the
    // closest active requester wins. Distance 0 is ptr+1, NREQ-1 is ptr.
    always_comb begin
        w_best   = NREQ;
        w_sel    = 0;
        w_dist   = 0;
        any_o    = 1'b0;
        gnt_o    = '0;
        gnt_id_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_dist = (i + NREQ - 1 - int'(ptr_i)) % NREQ;
            if (req_i[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_sel  = i;
                any_o  = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            gnt_o[i] = any_o && (w_sel == i);
        end
        gnt_id_o = IDW'(w_sel);
    end

endmodule : ula_rr_grant
`default_nettype wire

// File: rtl/ula_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ula_arbiter
//  Description : Round-robin arbiter/sequencer sharing one external 8-bit
//                74181-style ALU between NREQ requesters. Three-state FSM:
//                IDLE grants and latches an operation, EXEC drives the ALU
//                from the operand register and captures its outputs, RESP
//                holds the tagged result until the consumer accepts it.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                req_*               - per-requester packed operations
//                req_ready           - one-hot accept, IDLE only
//                alu_*               - to/from the external ALU
//                rsp_*               - tagged result, valid/ready handshake
//  Options     : ULA_ARB_STATS_EN adds stats_clr input and grant_count output
//                (one saturating 16-bit grant counter per requester).
//  Revision    : 1.0 - initial release
// ============================================================================
module ula_arbiter
    import ula_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef ULA_ARB_STATS_EN
    input  logic                   stats_clr,
    output logic [STAT_W*NREQ-1:0] grant_count,
`endif
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [ULA_W*NREQ-1:0]  req_a,
    input  logic [ULA_W*NREQ-1:0]  req_b,
    input  logic [ULA_SW*NREQ-1:0] req_s,
    input  logic [NREQ-1:0]        req_m,
    input  logic [NREQ-1:0]        req_cin,
    output logic [ULA_W-1:0]       alu_a,
    output logic [ULA_W-1:0]       alu_b,
    output logic [ULA_SW-1:0]      alu_s,
    output logic                   alu_m,
    output logic                   alu_cin,
    input  logic [ULA_W-1:0]       alu_f,
    input  logic                   alu_eq,
    input  logic                   alu_cout,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [ULA_W-1:0]       rsp_f,
    output logic                   rsp_eq,
    output logic                   rsp_cout
);

    arb_state_e       state_q;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   id_q;
    ula_op_t          op_q;
    logic             rsp_valid_q;
    logic [ULA_W-1:0] rsp_f_q;
    logic             rsp_eq_q;
    logic             rsp_cout_q;

    logic [NREQ-1:0]  w_gnt;
    logic [IDW-1:0]   w_gnt_id;
    logic             w_any;
    logic             w_accept;
    ula_op_t          w_sel_op;

    ula_rr_grant #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_grant (
        .req_i    (req_valid),
        .ptr_i    (ptr_q),
        .gnt_o    (w_gnt),
        .gnt_id_o (w_gnt_id),
        .any_o    (w_any)
    );

    // Only the granted requester's fields are observed; the one-hot grant
    // keeps unselected requesters out of the mux.
    always_comb begin
        w_sel_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_op.a   = req_a[i*ULA_W +: ULA_W];
                w_sel_op.b   = req_b[i*ULA_W +: ULA_W];
                w_sel_op.s   = req_s[i*ULA_SW +: ULA_SW];
                w_sel_op.m   = req_m[i];
                w_sel_op.cin = req_cin[i];
            end
        end
    end

    // Ready is offered only in IDLE and is forced low while reset is held.
    assign w_accept  = (state_q == IDLE) && w_any && !rst;
    assign req_ready = ((state_q == IDLE) && !rst) ? w_gnt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= IDW'(NREQ - 1);
            id_q        <= '0;
            op_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_f_q     <= '0;
            rsp_eq_q    <= 1'b0;
            rsp_cout_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (w_any) begin
                        op_q    <= w_sel_op;
                        ptr_q   <= w_gnt_id;
                        id_q    <= w_gnt_id;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    // ALU inputs have been steady from op_q for the whole cycle.
                    rsp_f_q     <= alu_f;
                    rsp_eq_q    <= alu_eq;
                    rsp_cout_q  <= alu_cout;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_a     = op_q.a;
    assign alu_b     = op_q.b;
    assign alu_s     = op_q.s;
    assign alu_m     = op_q.m;
    assign alu_cin   = op_q.cin;

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_f     = rsp_f_q;
    assign rsp_eq    = rsp_eq_q;
    assign rsp_cout  = rsp_cout_q;

`ifdef ULA_ARB_STATS_EN
    logic [STAT_W-1:0] cnt_q [NREQ];

    // Clear takes precedence over a same-cycle grant; counters stick at max.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (rst || stats_clr) begin
                cnt_q[i] <= '0;
            end else if (w_accept && w_gnt[i] && (cnt_q[i] != '1)) begin
                cnt_q[i] <= cnt_q[i] + STAT_W'(1);
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt_pack
        assign grant_count[gi*STAT_W +: STAT_W] = cnt_q[gi];
    end
`endif

endmodule : ula_arbiter
`default_nettype wire

// File: tb/tb_ula_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ula_arbiter
//  Description : Scoreboard bench for ula_arbiter with a behavioural 74181x2
//                ALU on the alu_* ports. Stimulus pushes expected responses;
//                a negedge monitor pops and compares. ULA_ARB_STATS_EN also
//                exercises the grant counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ula_arbiter;
    import ula_arb_pkg::*;

    localparam int NREQ = 2;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [8*NREQ-1:0] req_a, req_b;
    logic [4*NREQ-1:0] req_s;
    logic [NREQ-1:0]   req_m, req_cin;
    logic [7:0]        alu_a, alu_b, alu_f;
    logic [3:0]        alu_s;
    logic              alu_m, alu_cin, alu_eq, alu_cout;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [IDW-1:0]    rsp_id;
    logic [7:0]        rsp_f;
    logic              rsp_eq, rsp_cout;
`ifdef ULA_ARB_STATS_EN
    logic              stats_clr = 1'b0;
    logic [16*NREQ-1:0] grant_count;
`endif

    ula_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef ULA_ARB_STATS_EN
        .stats_clr  (stats_clr),
        .grant_count(grant_count),
`endif
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_s      (req_s),
        .req_m      (req_m),
        .req_cin    (req_cin),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_s      (alu_s),
        .alu_m      (alu_m),
        .alu_cin    (alu_cin),
        .alu_f      (alu_f),
        .alu_eq     (alu_eq),
        .alu_cout   (alu_cout),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_f      (rsp_f),
        .rsp_eq     (rsp_eq),
        .rsp_cout   (rsp_cout)
    );

    always #5 clk = ~clk;

    // ---------------- external ALU: two cascaded 74181 (active-high data) ---
    function automatic logic [9:0] alu181(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] s, input logic m,
                                          input logic cin);
        logic [7:0] f;
        logic       c, p, g;
        f = '0;
        c = ~cin;
        for (int i = 0; i < 8; i++) begin
            p    = a[i] | (b[i] & s[0]) | (~b[i] & s[1]);
            g    = (a[i] & ~b[i] & s[2]) | (a[i] & b[i] & s[3]);
            f[i] = (p ^ g) ^ (m ? 1'b1 : c);
            c    = g | (p & c);
        end
        return {&f, ~c, f};
    endfunction

    assign {alu_eq, alu_cout, alu_f} = alu181(alu_a, alu_b, alu_s, alu_m, alu_cin);

    // ---------------- reference: datasheet function table -------------------
    function automatic logic [7:0] ref_logic(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] s);
        case (s)
            4'd0:    return ~a;
            4'd1:    return ~(a | b);
            4'd2:    return ~a & b;
            4'd3:    return 8'h00;
            4'd4:    return ~(a & b);
            4'd5:    return ~b;
            4'd6:    return a ^ b;
            4'd7:    return a & ~b;
            4'd8:    return ~a | b;
            4'd9:    return ~(a ^ b);
            4'd10:   return b;
            4'd11:   return a & b;
            4'd12:   return 8'hFF;
            4'd13:   return a | ~b;
            4'd14:   return a | b;
            default: return a;
        endcase
    endfunction

    // Arithmetic subset: 1001 = A plus B, 0110 = A minus B minus 1;
    // carry-in and carry-out are active low.
    function automatic logic [8:0] ref_arith(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] s, input logic cin);
        logic [8:0] sum;
        if (s == 4'b1001) sum = {1'b0, a} + {1'b0, b}  + 9'(!cin);
        else              sum = {1'b0, a} + {1'b0, ~b} + 9'(!cin);
        return {~sum[8], sum[7:0]};
    endfunction

    // ---------------- requester operation storage ---------------------------
    logic [7:0] op_a[NREQ], op_b[NREQ], fx_a[NREQ], fx_b[NREQ];
    logic [3:0] op_s[NREQ], fx_s[NREQ];
    logic       op_m[NREQ], op_cin[NREQ], fx_m[NREQ], fx_cin[NREQ];
    bit         fixed[NREQ];
    int         pend[NREQ];
    int         rsp_mode = 0;   // 0: always ready, 1: random, 2: held low

    always_comb begin
        req_a = '0; req_b = '0; req_s = '0; req_m = '0; req_cin = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*8 +: 8] = op_a[i];
            req_b[i*8 +: 8] = op_b[i];
            req_s[i*4 +: 4] = op_s[i];
            req_m[i]        = op_m[i];
            req_cin[i]      = op_cin[i];
        end
    end

    // ---------------- scoreboard state --------------------------------------
    typedef struct {
        logic [IDW-1:0] id;
        logic [7:0]     a, b, f;
        logic [3:0]     s;
        logic           m, cin, eq, cout, chk_cout;
        int             cyc;
    } exp_t;

    exp_t exp_q[$];
    int   gnt_hist[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   ptr      = NREQ - 1;
    bit   busy     = 1'b0;
    bit   rst_prev = 1'b1;
    int   first_win = -1;
    int   n_rsp[NREQ];
    logic [7:0]     last_f  = '0;
    logic [IDW-1:0] last_id = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ------------------------------------------------
    always @(negedge clk) begin : mon
        int              win;
        int              idx;
        exp_t            e;
        logic [NREQ-1:0] er;
        logic [8:0]      ar;
        cyc++;
        if (rst) begin
            check("req_ready_in_rst", 32'(req_ready), 32'(0));
            exp_q.delete();
            busy      = 1'b0;
            ptr       = NREQ - 1;
            first_win = -1;
        end else begin
            if (rst_prev) check("rsp_valid_after_rst", 32'(rsp_valid), 32'(0));
            if (busy) begin
                e = exp_q[0];
                check("req_ready_busy", 32'(req_ready), 32'(0));
                if (cyc - e.cyc == 1) begin
                    check("alu_a", 32'(alu_a), 32'(e.a));
                    check("alu_b", 32'(alu_b), 32'(e.b));
                    check("alu_s", 32'(alu_s), 32'(e.s));
                    check("alu_m_cin", 32'({alu_m, alu_cin}), 32'({e.m, e.cin}));
                    check("rsp_early", 32'(rsp_valid), 32'(0));
                end else if (cyc - e.cyc == 2) begin
                    check("rsp_latency", 32'(rsp_valid), 32'(1));
                end
                if (rsp_valid) begin
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                    check("rsp_f", 32'(rsp_f), 32'(e.f));
                    check("rsp_eq", 32'(rsp_eq), 32'(e.eq));
                    if (e.chk_cout) check("rsp_cout", 32'(rsp_cout), 32'(e.cout));
                    if (rsp_ready) begin
                        last_f  = rsp_f;
                        last_id = rsp_id;
                        n_rsp[int'(e.id)]++;
                        void'(exp_q.pop_front());
                        busy = 1'b0;
                    end
                end
            end else begin
                check("rsp_valid_idle", 32'(rsp_valid), 32'(0));
                win = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    idx = (ptr + k) % NREQ;
                    if (win < 0 && req_valid[idx]) win = idx;
                end
                er = '0;
                if (win >= 0) er[win] = 1'b1;
                check("req_ready", 32'(req_ready), 32'(er));
                if (win >= 0) begin
                    e.id  = IDW'(win);
                    e.a   = op_a[win];
                    e.b   = op_b[win];
                    e.s   = op_s[win];
                    e.m   = op_m[win];
                    e.cin = op_cin[win];
                    if (e.m) begin
                        e.f        = ref_logic(e.a, e.b, e.s);
                        e.cout     = 1'b0;
                        e.chk_cout = 1'b0;
                    end else begin
                        ar         = ref_arith(e.a, e.b, e.s, e.cin);
                        e.f        = ar[7:0];
                        e.cout     = ar[8];
                        e.chk_cout = 1'b1;
                    end
                    e.eq  = (e.f == 8'hFF);
                    e.cyc = cyc;
                    exp_q.push_back(e);
                    gnt_hist.push_back(win);
                    if (first_win < 0) first_win = win;
                    ptr  = win;
                    busy = 1'b1;
                end
            end
        end
        rst_prev = rst;
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic set_fixed(input int i, input logic [7:0] a, input logic [7:0] b,
                             input logic [3:0] s, input logic m, input logic cin);
        fixed[i] = 1'b1;
        fx_a[i] = a; fx_b[i] = b; fx_s[i] = s; fx_m[i] = m; fx_cin[i] = cin;
    endtask

    // One clock: note handshakes before the edge, update drivers after it.
    task automatic tick();
        logic [NREQ-1:0] hs;
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (hs[i]) begin
                req_valid[i] = 1'b0;
                if (pend[i] > 0) pend[i]--;
            end
            if (!req_valid[i] && pend[i] > 0 && !rst) begin
                if (fixed[i]) begin
                    op_a[i] = fx_a[i]; op_b[i] = fx_b[i]; op_s[i] = fx_s[i];
                    op_m[i] = fx_m[i]; op_cin[i] = fx_cin[i];
                end else begin
                    op_a[i]   = 8'($urandom);
                    op_b[i]   = 8'($urandom);
                    op_m[i]   = 1'($urandom);
                    op_s[i]   = op_m[i] ? 4'($urandom)
                                        : (($urandom_range(0, 1) == 1) ? 4'b1001 : 4'b0110);
                    op_cin[i] = 1'($urandom);
                end
                req_valid[i] = 1'b1;
            end
        end
        case (rsp_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'($urandom);
            default: rsp_ready = 1'b0;
        endcase
    endtask

    function automatic int pend_total();
        int t = 0;
        for (int i = 0; i < NREQ; i++) t += pend[i];
        return t;
    endfunction

    task automatic run_until_idle(input int bound);
        int n = 0;
        while (n < bound && !(pend_total() == 0 && req_valid == '0 && !busy)) begin
            tick();
            n++;
        end
        if (n >= bound) begin
            n_checks++;
            n_err++;
            $display("FAIL idle_timeout: still busy after %0d cycles, pending %0d", n, pend_total());
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence -----------------------------------------
    initial begin : main
        int n;
        int r1;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = '0; op_b[i] = '0; op_s[i] = '0; op_m[i] = 1'b0; op_cin[i] = 1'b0;
            fixed[i] = 1'b0; pend[i] = 0; n_rsp[i] = 0;
        end
        repeat (3) tick();
        rst = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_id", 32'(rsp_id), 32'(0));
        check("rst_rsp_f", 32'(rsp_f), 32'(0));
        check("rst_rsp_flags", 32'({rsp_eq, rsp_cout}), 32'(0));
        check("rst_alu_ab", 32'({alu_a, alu_b}), 32'(0));
        check("rst_alu_smc", 32'({alu_s, alu_m, alu_cin}), 32'(0));
        @(posedge clk);
        #1;

        // Contention: OR ops on both requesters, grants must alternate from 0
        set_fixed(0, 8'hA5, 8'h0F, 4'b1110, 1'b1, 1'b1);
        set_fixed(1, 8'h30, 8'h81, 4'b1110, 1'b1, 1'b1);
        gnt_hist.delete();
        pend[0] = 2; pend[1] = 2;
        run_until_idle(100);
        check("contention_len", 32'(gnt_hist.size()), 32'(4));
        for (int k = 0; k < 4 && k < gnt_hist.size(); k++)
            check("contention_order", 32'(gnt_hist[k]), 32'(k % 2));

        // Response backpressure: both pending, consumer stalls 5 cycles
        gnt_hist.delete();
        rsp_mode = 2;
        pend[0] = 1; pend[1] = 1;
        n = 0;
        while (!rsp_valid && n < 20) begin tick(); n++; end
        check("bp_rsp_seen", 32'(rsp_valid), 32'(1));
        repeat (5) tick();
        rsp_mode = 0;
        run_until_idle(50);
        check("bp_order_len", 32'(gnt_hist.size()), 32'(2));
        if (gnt_hist.size() == 2)
            check("bp_second_grant", 32'(gnt_hist[1]), 32'(1));

        // Single XOR op from requester 0
        set_fixed(0, 8'h3C, 8'h0F, 4'b0110, 1'b1, 1'b1);
        pend[0] = 1;
        run_until_idle(50);
        check("xor_f", 32'(last_f), 32'(8'h33));
        check("xor_id", 32'(last_id), 32'(0));

        // Mid-operation reset: accept from req0, reset while in EXEC
        fixed[0] = 1'b0;
        pend[0] = 1;
        n = 0;
        while (!busy && n < 20) begin tick(); n++; end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pend[0] = 1; pend[1] = 1;
        run_until_idle(50);
        check("post_rst_first_grant", 32'(first_win), 32'(0));

        // Lone requester 1: three back-to-back AND ops
        set_fixed(1, 8'hF0, 8'h3C, 4'b1011, 1'b1, 1'b1);
        r1 = n_rsp[1];
        pend[1] = 3;
        run_until_idle(50);
        check("lone_count", 32'(n_rsp[1] - r1), 32'(3));
        check("lone_f", 32'(last_f), 32'(8'h30));
        check("lone_id", 32'(last_id), 32'(1));

        // Randomised operations with random response backpressure
        fixed[0] = 1'b0; fixed[1] = 1'b0;
        rsp_mode = 1;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NREQ; i++) pend[i] = $urandom_range(0, 6);
            run_until_idle(600);
        end
        rsp_mode = 0;

`ifdef ULA_ARB_STATS_EN
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        pend[0] = 3; pend[1] = 2;
        run_until_idle(100);
        @(negedge clk);
        check("grant_count", 32'(grant_count), 32'h0002_0003);
        @(posedge clk);
        #1;
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        @(negedge clk);
        check("grant_count_clr", 32'(grant_count), 32'(0));
`endif

        repeat (2) tick();
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule : tb_ula_arbiter
`default_nettype wire
